// File: rtl/menshen_dispatch_pkg.sv
// Shared types for the Menshen pipeline dispatcher: FSM states, qid range entries
// and the range-match helper.
package menshen_dispatch_pkg;

  localparam int CNT_W     = 32;
  localparam int QID_W_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  typedef struct packed {
    logic [QID_W_MAX-1:0] base;
    logic [QID_W_MAX-1:0] count;
  } qid_range_t;

  // One extra bit keeps base+count-1 from wrapping at the top of the qid space.
  function automatic logic range_hit(input logic [QID_W_MAX-1:0] qid, input qid_range_t r);
    logic [QID_W_MAX:0] last;
    last = {1'b0, r.base} + {1'b0, r.count} - (QID_W_MAX+1)'(1);
    return (r.count != '0) && (qid >= r.base) && ({1'b0, qid} <= last);
  endfunction

endpackage

// File: rtl/axis_reg_slice_1d.sv
// One-entry AXI-Stream output slot; free when empty or being drained this cycle.
module axis_reg_slice_1d #(
  parameter int DW = 512,
  parameter int KW = DW/8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [DW-1:0] i_data,
  input  logic [KW-1:0] i_keep,
  input  logic          i_last,
  input  logic          i_ready,
  output logic          o_free,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output logic [KW-1:0] o_keep,
  output logic          o_last
);

  logic          r_valid;
  logic [DW-1:0] r_data;
  logic [KW-1:0] r_keep;
  logic          r_last;

  assign o_free  = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_keep  = r_keep;
  assign o_last  = r_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_keep  <= i_keep;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/menshen_pipe_dispatch.sv
// Steers whole H2C packets to one Menshen pipeline by first-beat qid range lookup,
// or drops them; keeps per-pipeline packet counters and a drop counter.
module menshen_pipe_dispatch
  import menshen_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int NUM_PIPE   = 2,
  parameter int QID_W      = 11,
  parameter int IDX_W      = (NUM_PIPE > 1) ? $clog2(NUM_PIPE) : 1
) (
  input  logic                           axis_aclk,
  input  logic                           axis_rst,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0]        s_axis_tkeep,
  input  logic [QID_W-1:0]               s_axis_tuser_qid,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [NUM_PIPE*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_PIPE*DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic [NUM_PIPE-1:0]            m_axis_tvalid,
  output logic [NUM_PIPE-1:0]            m_axis_tlast,
  input  logic [NUM_PIPE-1:0]            m_axis_tready,
  input  logic                           cfg_wr_en,
  input  logic [IDX_W-1:0]               cfg_wr_idx,
  input  logic [QID_W-1:0]               cfg_wr_base,
  input  logic [QID_W-1:0]               cfg_wr_count,
  output logic [NUM_PIPE*CNT_W-1:0]      pkt_cnt,
  output logic [CNT_W-1:0]               drop_cnt
);

  localparam int KW = DATA_WIDTH/8;

  state_e                          r_state;
  logic [IDX_W-1:0]                r_sel;
  qid_range_t                      r_tbl [NUM_PIPE];
  logic [NUM_PIPE-1:0][CNT_W-1:0]  r_pkt_cnt;
  logic [CNT_W-1:0]                r_drop_cnt;

  logic [NUM_PIPE-1:0] w_hit_vec;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic [NUM_PIPE-1:0] w_free;
  logic [NUM_PIPE-1:0] w_load;
  logic                w_tready;
  logic                w_acc;

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_PIPE-1; i >= 0; i--) begin
      w_hit_vec[i] = range_hit(QID_W_MAX'(s_axis_tuser_qid), r_tbl[i]);
      if (w_hit_vec[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_tready = 1'b0;
    if (!axis_rst) begin
      case (r_state)
        ST_IDLE: w_tready = w_hit ? w_free[w_hit_idx] : 1'b1;
        ST_FWD:  w_tready = w_free[r_sel];
        ST_DROP: w_tready = 1'b1;
        default: w_tready = 1'b0;
      endcase
    end
  end

  assign s_axis_tready = w_tready;
  assign w_acc         = s_axis_tvalid && w_tready;

  always_comb begin
    for (int i = 0; i < NUM_PIPE; i++) begin
      w_load[i] = w_acc &&
                  (((r_state == ST_IDLE) && w_hit && (w_hit_idx == IDX_W'(i))) ||
                   ((r_state == ST_FWD) && (r_sel == IDX_W'(i))));
    end
  end

  for (genvar g = 0; g < NUM_PIPE; g++) begin : g_slot
    axis_reg_slice_1d #(.DW(DATA_WIDTH), .KW(KW)) u_slot (
      .clk     (axis_aclk),
      .rst     (axis_rst),
      .i_load  (w_load[g]),
      .i_data  (s_axis_tdata),
      .i_keep  (s_axis_tkeep),
      .i_last  (s_axis_tlast),
      .i_ready (m_axis_tready[g]),
      .o_free  (w_free[g]),
      .o_valid (m_axis_tvalid[g]),
      .o_data  (m_axis_tdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_keep  (m_axis_tkeep[g*KW +: KW]),
      .o_last  (m_axis_tlast[g])
    );
  end

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      for (int i = 0; i < NUM_PIPE; i++) r_tbl[i] <= '0;
    end else if (cfg_wr_en) begin
      for (int i = 0; i < NUM_PIPE; i++)
        if (cfg_wr_idx == IDX_W'(i))
          r_tbl[i] <= '{base: QID_W_MAX'(cfg_wr_base), count: QID_W_MAX'(cfg_wr_count)};
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_rst) begin
    if (axis_rst) begin
      r_state    <= ST_IDLE;
      r_sel      <= '0;
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_acc) begin
          if (w_hit) begin
            r_sel <= w_hit_idx;
            if (s_axis_tlast) r_pkt_cnt[w_hit_idx] <= r_pkt_cnt[w_hit_idx] + 1'b1;
            else              r_state <= ST_FWD;
          end else begin
            if (s_axis_tlast) r_drop_cnt <= r_drop_cnt + 1'b1;
            else              r_state <= ST_DROP;
          end
        end
        ST_FWD: if (w_acc && s_axis_tlast) begin
          r_pkt_cnt[r_sel] <= r_pkt_cnt[r_sel] + 1'b1;
          r_state          <= ST_IDLE;
        end
        ST_DROP: if (w_acc && s_axis_tlast) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_menshen_pipe_dispatch.sv
// Scoreboard bench for menshen_pipe_dispatch: expected beats queued per pipe on
// acceptance, popped and compared on each output handshake.
module tb_menshen_pipe_dispatch;

  localparam int DW = 512;
  localparam int KW = DW/8;
  localparam int NP = 2;
  localparam int QW = 11;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [DW-1:0]      s_tdata = '0;
  logic [KW-1:0]      s_tkeep = '0;
  logic [QW-1:0]      s_tqid = '0;
  logic               s_tvalid = 1'b0;
  logic               s_tlast = 1'b0;
  logic               s_tready;
  logic [NP*DW-1:0]   m_tdata;
  logic [NP*KW-1:0]   m_tkeep;
  logic [NP-1:0]      m_tvalid;
  logic [NP-1:0]      m_tlast;
  logic [NP-1:0]      rdy = '1;
  logic               cfg_en = 1'b0;
  logic               cfg_idx = 1'b0;
  logic [QW-1:0]      cfg_base = '0;
  logic [QW-1:0]      cfg_cnt = '0;
  logic [NP*32-1:0]   pkt_cnt;
  logic [31:0]        drop_cnt;

  int    n_chk = 0;
  int    n_fail = 0;
  int    exp_pkt [NP];
  int    exp_drop = 0;
  beat_t q0 [$];
  beat_t q1 [$];

  always #5 clk = ~clk;

  menshen_pipe_dispatch #(.DATA_WIDTH(DW), .NUM_PIPE(NP), .QID_W(QW)) dut (
    .axis_aclk        (clk),
    .axis_rst         (rst),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (s_tkeep),
    .s_axis_tuser_qid (s_tqid),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .s_axis_tready    (s_tready),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (rdy),
    .cfg_wr_en        (cfg_en),
    .cfg_wr_idx       (cfg_idx),
    .cfg_wr_base      (cfg_base),
    .cfg_wr_count     (cfg_cnt),
    .pkt_cnt          (pkt_cnt),
    .drop_cnt         (drop_cnt)
  );

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        if (m_tvalid[i] && rdy[i]) begin
          beat_t e;
          if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
            chk($sformatf("p%0d_unexpected_beat", i), m_tvalid[i], 1'b0);
          end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("p%0d_data", i), m_tdata[i*DW +: DW], e.d);
            chk($sformatf("p%0d_keep", i), m_tkeep[i*KW +: KW], e.k);
            chk($sformatf("p%0d_last", i), m_tlast[i], e.l);
          end
        end
      end
    end
  end

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic cfg_write(input logic idx, input int base, input int cnt);
    cfg_en = 1'b1; cfg_idx = idx; cfg_base = QW'(base); cfg_cnt = QW'(cnt);
    @(posedge clk); #1;
    cfg_en = 1'b0;
  endtask

  task automatic send_pkt(input int qid, input int nb, input int pipe, input logic [31:0] seed);
    for (int b = 0; b < nb; b++) begin
      beat_t e;
      bit    acc;
      e = '0;
      e.d[31:0]     = seed + 32'(b);
      e.d[DW-1 -: 32] = ~seed;
      e.k = (b == nb-1) ? KW'(64'h0000_0000_00FF_FFFF) : '1;
      e.l = (b == nb-1);
      s_tdata = e.d; s_tkeep = e.k; s_tlast = e.l; s_tvalid = 1'b1;
      s_tqid  = (b == 0) ? QW'(qid) : QW'(qid + 3*b + 1);
      acc = 1'b0;
      for (int t = 0; t < 60 && !acc; t++) begin
        @(negedge clk);
        if (pipe < 0 && t == 0) chk("drop_tready", s_tready, 1'b1);
        if (s_tready) begin
          acc = 1'b1;
          if (pipe == 0) q0.push_back(e);
          else if (pipe == 1) q1.push_back(e);
        end
        @(posedge clk); #1;
      end
      chk("beat_accept", acc, 1'b1);
      if (acc && e.l) begin
        if (pipe >= 0) exp_pkt[pipe]++;
        else exp_drop++;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic drain_and_check_counts(input string tag);
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk({tag, "_pkt0"}, pkt_cnt[31:0], exp_pkt[0]);
    chk({tag, "_pkt1"}, pkt_cnt[63:32], exp_pkt[1]);
    chk({tag, "_drop"}, drop_cnt, exp_drop);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_pkt[0] = 0; exp_pkt[1] = 0;
    #12;
    chk("rst_tready", s_tready, 1'b0);
    chk("rst_tvalid", m_tvalid, '0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_pkt", pkt_cnt, '0);
    chk("rst_drop", drop_cnt, '0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Table {0: 0..0, 1: 2..2}
    cfg_write(1'b0, 0, 1);
    cfg_write(1'b1, 2, 1);
    send_pkt(0, 1, 0, 32'h0000_0900);
    drain_and_check_counts("single");

    send_pkt(2, 3, 1, 32'h0001_0000);
    drain_and_check_counts("three_beat");

    send_pkt(5, 2, -1, 32'h0002_0000);
    drain_and_check_counts("drop");

    // Pipe 1 stalls for 4 cycles after its first beat.
    rdy[1] = 1'b0;
    fork
      send_pkt(2, 3, 1, 32'h0003_0000);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_tready", s_tready, 1'b0);
        repeat (2) @(posedge clk); #1;
        rdy[1] = 1'b1;
      end
    join
    drain_and_check_counts("stall");

    // Pipe 1 held full while pipe 0 carries a packet.
    rdy[1] = 1'b0;
    send_pkt(2, 1, 1, 32'h0004_0000);
    send_pkt(0, 2, 0, 32'h0005_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("p1_held_valid", m_tvalid[1], 1'b1);
    @(posedge clk); #1;
    rdy[1] = 1'b1;
    drain_and_check_counts("concurrent");

    // Overlap: lowest index wins; rewrite mid-packet keeps the latched pipe.
    cfg_write(1'b0, 0, 4);
    fork
      send_pkt(2, 3, 0, 32'h0006_0000);
      begin
        @(posedge clk); #1;
        cfg_write(1'b0, 0, 0);
      end
    join
    send_pkt(2, 1, 1, 32'h0007_0000);
    drain_and_check_counts("overlap");

    // Range running past the top of the qid space must not wrap.
    cfg_write(1'b1, 2040, 20);
    send_pkt(2047, 2, 1, 32'h0008_0000);
    send_pkt(3, 1, -1, 32'h0009_0000);
    drain_and_check_counts("top_range");

    // Reset during beat 2 of a 4-beat packet.
    cfg_write(1'b0, 0, 1);
    s_tdata = DW'(32'h000A_0000); s_tkeep = '1; s_tlast = 1'b0; s_tqid = '0; s_tvalid = 1'b1;
    @(posedge clk); #1;
    s_tdata = DW'(32'h000A_0001);
    #2; rst = 1'b1; #1;
    s_tvalid = 1'b0;
    chk("midrst_tvalid", m_tvalid, '0);
    chk("midrst_pkt", pkt_cnt, '0);
    chk("midrst_drop", drop_cnt, '0);
    chk("midrst_tready", s_tready, 1'b0);
    q0.delete(); q1.delete();
    exp_pkt[0] = 0; exp_pkt[1] = 0; exp_drop = 0;
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    send_pkt(0, 1, -1, 32'h000B_0000);
    cfg_write(1'b0, 0, 1);
    send_pkt(0, 2, 0, 32'h000C_0000);
    drain_and_check_counts("post_reset");

    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
